// File: rtl/steer_pkg.sv
// Shared constants and types for the steering slew controller and its frame-locked helpers.
package steer_pkg;

   localparam int unsigned STEER_MIN       = 115;
   localparam int unsigned STEER_MAX       = 185;
   localparam int unsigned STEER_CENTER    = 150;
   localparam int unsigned PWM_FRAME_TICKS = 607;

   typedef logic [7:0] steer_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SLEW     = 2'd1,
      FAILSAFE = 2'd2
   } steer_state_e;

endpackage

// File: rtl/steer_tick_gen.sv
// Free-running PWM-frame counter; tick is high for the last cycle of every frame.
module steer_tick_gen
   import steer_pkg::*;
#(
   parameter int unsigned TICK_PERIOD = PWM_FRAME_TICKS
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = $clog2(TICK_PERIOD);

   logic [CW-1:0] r_cnt;
   logic          r_tick;

   // tick is registered one count early so it coincides with r_cnt == TICK_PERIOD-1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         if (r_cnt == CW'(TICK_PERIOD - 1)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
         r_tick <= (r_cnt == CW'(TICK_PERIOD - 2));
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/steer_slew_ctrl.sv
// Steering command clamp, rate limiter and watchdog feeding the PWM direction stage.
// Optional STEER_TRIM_EN adds a signed 4-bit trim applied to commands at accept.
module steer_slew_ctrl
   import steer_pkg::*;
#(
   parameter int unsigned MIN_CMD     = STEER_MIN,
   parameter int unsigned MAX_CMD     = STEER_MAX,
   parameter int unsigned CENTER_CMD  = STEER_CENTER,
   parameter int unsigned STEP        = 1,
   parameter int unsigned TICK_PERIOD = PWM_FRAME_TICKS,
   parameter int unsigned WD_TICKS    = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
`ifdef STEER_TRIM_EN
   input  logic [3:0] trim,
`endif
   output logic       cmd_ready,
   output logic [7:0] steer_out,
   output logic       at_target,
   output logic       cmd_sat,
   output logic       wd_timeout
);

   localparam int unsigned WD_W = $clog2(WD_TICKS + 1);

   steer_t          r_steer;
   steer_t          r_target;
   steer_state_e    r_state;
   logic [WD_W-1:0] r_wd;
   logic            r_at_target;
   logic            r_cmd_sat;
   logic            r_wd_timeout;

   logic               w_tick;
   logic               w_accept;
   logic signed [9:0]  w_req;
   steer_t             w_clamped;
   logic               w_sat;
   logic signed [8:0]  w_diff;
   steer_t             w_steer_nxt;
   steer_t             w_target_nxt;
   logic [WD_W-1:0]    w_wd_nxt;
   logic               w_wd_expire;
   steer_state_e       w_state_nxt;

   steer_tick_gen #(
      .TICK_PERIOD(TICK_PERIOD)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   assign cmd_ready = enable;
   assign w_accept  = cmd_valid & enable;

`ifdef STEER_TRIM_EN
   assign w_req = $signed({2'b00, cmd_data}) + 10'($signed(trim));
`else
   assign w_req = $signed({2'b00, cmd_data});
`endif

   // Clamp the requested value into the servo-safe window
   always_comb begin
      w_clamped = w_req[7:0];
      w_sat     = 1'b0;
      if (w_req < $signed(10'(MIN_CMD))) begin
         w_clamped = 8'(MIN_CMD);
         w_sat     = 1'b1;
      end else if (w_req > $signed(10'(MAX_CMD))) begin
         w_clamped = 8'(MAX_CMD);
         w_sat     = 1'b1;
      end
   end

   assign w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_steer});

   // Rate-limited step toward the current target; lands exactly on it when close
   always_comb begin
      w_steer_nxt = r_steer;
      if (w_tick) begin
         if (w_diff > 9'sd0) begin
            w_steer_nxt = (w_diff > $signed(9'(STEP))) ? r_steer + 8'(STEP) : r_target;
         end else if (w_diff < 9'sd0) begin
            w_steer_nxt = (-w_diff > $signed(9'(STEP))) ? r_steer - 8'(STEP) : r_target;
         end
      end
   end

   // Expiry is the tick that would carry the count to WD_TICKS; a same-edge accept wins
   assign w_wd_expire = enable & w_tick & ~w_accept & (r_wd == WD_W'(WD_TICKS - 1));

   always_comb begin
      w_wd_nxt = r_wd;
      if (!enable || w_accept) begin
         w_wd_nxt = '0;
      end else if (w_tick && (r_wd != WD_W'(WD_TICKS))) begin
         w_wd_nxt = r_wd + WD_W'(1);
      end
   end

   always_comb begin
      w_target_nxt = r_target;
      if (!enable) begin
         w_target_nxt = 8'(CENTER_CMD);
      end else if (w_accept) begin
         w_target_nxt = w_clamped;
      end else if (w_wd_expire) begin
         w_target_nxt = 8'(CENTER_CMD);
      end
   end

   always_comb begin
      w_state_nxt = (w_target_nxt == w_steer_nxt) ? IDLE : SLEW;
      if (w_wd_expire) begin
         w_state_nxt = FAILSAFE;
      end else if ((r_state == FAILSAFE) && enable && !w_accept) begin
         w_state_nxt = FAILSAFE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_steer      <= 8'(CENTER_CMD);
         r_target     <= 8'(CENTER_CMD);
         r_state      <= IDLE;
         r_wd         <= '0;
         r_at_target  <= 1'b1;
         r_cmd_sat    <= 1'b0;
         r_wd_timeout <= 1'b0;
      end else begin
         r_steer      <= w_steer_nxt;
         r_target     <= w_target_nxt;
         r_state      <= w_state_nxt;
         r_wd         <= w_wd_nxt;
         r_at_target  <= (w_steer_nxt == w_target_nxt);
         r_cmd_sat    <= w_accept & w_sat;
         r_wd_timeout <= (w_state_nxt == FAILSAFE);
      end
   end

   assign steer_out  = r_steer;
   assign at_target  = r_at_target;
   assign cmd_sat    = r_cmd_sat;
   assign wd_timeout = r_wd_timeout;

endmodule

// File: doc/steer_slew_ctrl.md
Name: steer_slew_ctrl

Overview:
- Upstream feeder for the steering PWM stage. Its steer_out drives the 8-bit data_in of the PWM direction generator, where PWM match = data_in*2 and the valid match window is 229..371.
- Accepts steering commands over a valid/ready handshake and clamps them to the servo-safe range 115..185.
- Slews the output toward the clamped target at a bounded rate, one step per PWM frame.
- A watchdog returns steering to centre (150) if commands stop arriving.

Parameters:
- MIN_CMD, 115, lowest legal output (PWM match 230).
- MAX_CMD, 185, highest legal output (PWM match 370).
- CENTER_CMD, 150, reset/failsafe value (PWM match 300).
- STEP, 1, maximum output change per tick.
- TICK_PERIOD, 607, clock cycles per tick; equals one PWM frame.
- WD_TICKS, 50, ticks without an accepted command before failsafe.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  1 = accept commands; 0 = steer to centre
- cmd_valid  in  1  command present
- cmd_data  in  8  requested steering value, unsigned
- cmd_ready  out  1  block can accept a command
- steer_out  out  8  registered value to the PWM stage's data_in
- at_target  out  1  steer_out == target
- cmd_sat  out  1  one-cycle pulse: last accepted command was clamped
- wd_timeout  out  1  failsafe active

Behaviour:
- Reset (rst=0, asynchronous):
  - steer_out = target = CENTER_CMD.
  - State IDLE; tick and watchdog counters = 0.
  - at_target=1, cmd_sat=0, wd_timeout=0.
  - Release is synchronous to the next clk edge.
- cmd_ready = enable, combinational from the input. Accept occurs when cmd_valid & cmd_ready at a rising edge.
- Accept updates target the next cycle:
  - cmd_data < MIN_CMD gives MIN_CMD; cmd_data > MAX_CMD gives MAX_CMD; otherwise unchanged.
  - cmd_sat pulses for 1 cycle if clamping occurred.
- Tick generator: counter runs 0..TICK_PERIOD-1 and wraps; tick is asserted for one cycle at TICK_PERIOD-1. It runs continuously out of reset, independent of enable.
- Slew, on a tick only:
  - diff = target - steer_out, computed as 9-bit signed.
  - steer_out moves toward target by min(STEP, |diff|) and never overshoots.
  - diff = 0 leaves steer_out unchanged.
- FSM:
  - IDLE: steer_out==target. Go to SLEW when target changes.
  - SLEW: go to IDLE on the tick where steer_out reaches target.
  - FAILSAFE: entered from any state on watchdog expiry; target forced to CENTER_CMD; wd_timeout=1. Left on the next accepted command: goes to SLEW (or IDLE if the command equals steer_out), wd_timeout clears the cycle after accept.
- at_target = (steer_out == target), registered.
- Watchdog:
  - Counts ticks since the last accept; cleared on accept.
  - On reaching WD_TICKS it saturates and triggers FAILSAFE.
  - Counter width is $clog2(WD_TICKS+1).
- enable=0:
  - No accepts; target forced to CENTER_CMD.
  - Watchdog held at 0 and wd_timeout cleared; slewing continues toward centre.
- Simultaneous events:
  - Accept on a tick edge: that tick slews with the old target; the new target applies from the next tick.
  - Accept on the watchdog-expiry edge: accept wins; counter cleared; no FAILSAFE.
- Reset mid-slew: steer_out snaps immediately to CENTER_CMD.
- All outputs are registered except cmd_ready.

Optional Feature:
- Macro: STEER_TRIM_EN.
- Defined: adds input trim (4-bit signed, -8..+7). Target becomes clamp(cmd_data + sign-extended trim) using 10-bit signed arithmetic before the clamp. trim is sampled at accept only.
- Not defined: no trim port; target = clamp(cmd_data).

Decomposition:
- Package steer_pkg holds:
  - constants STEER_MIN=115, STEER_MAX=185, STEER_CENTER=150, PWM_FRAME_TICKS=607;
  - typedef steer_t (logic [7:0]);
  - enum steer_state_e {IDLE, SLEW, FAILSAFE}.
- Sub-module steer_tick_gen (parameter TICK_PERIOD; ports clk, rst, tick) holds the frame counter and is reusable by other PWM-frame-locked blocks.

Test Plan:
- Reset then idle 1000 cycles -> steer_out=150, at_target=1, cmd_ready=enable, wd_timeout=0.
- enable=1, send 160 -> target=160 next cycle; steer_out reaches 151..160 on ticks 1..10 (10*607 cycles); at_target rises after the 10th tick.
- Send 250, then 20 -> first clamps to 185 with a cmd_sat pulse; second clamps to 115 with a cmd_sat pulse; slew direction reverses without overshoot.
- From 170, no commands for 50 ticks -> wd_timeout=1 and the output walks back to 150. A new command 140 clears wd_timeout the next cycle and slews to 140.
- Accept 180 on the same edge as the 50th watchdog tick -> no FAILSAFE, wd_timeout stays 0. Accept on a slew tick uses the old target for that tick.
- Assert rst mid-slew at steer_out=165 -> steer_out=150 immediately, asynchronously. enable=0 while at 175 -> cmd_valid ignored and the output slews to 150.
